// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save add/subtract unit.
//   DEF_W   : default operand width
//   op_t    : operation select encoding (matches the add_sub port)
//   csa_ref : plain binary golden model, result returned unmasked in 32 bits;
//             callers reduce it mod 2^W for their width
package csa_pkg;

   localparam int DEF_W = 16;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

   function automatic logic [31:0] csa_ref(input logic [31:0] xs,
                                           input logic [31:0] xc,
                                           input logic [31:0] ys,
                                           input logic [31:0] yc,
                                           input op_t         op);
      logic [31:0] x;
      logic [31:0] y;
      x = xs + xc;
      y = ys + yc;
      return (op == OP_SUB) ? (x - y) : (x + y);
   endfunction

endpackage

// File: rtl/csa42_cell.sv
// One bit slice of the 4-2 compressor row (purely combinational).
//   xs, xc   : redundant X bits
//   ys, yc   : redundant Y bits, conditionally inverted by add_sub
//   cin      : horizontal carry from the previous slice's first full adder
//   add_sub  : 0 = add, 1 = subtract
//   s        : compressed sum bit (weight 2^i)
//   c        : compressed carry bit (weight 2^(i+1))
//   cout     : horizontal carry to the next slice (weight 2^(i+1))
module csa42_cell (
   input  logic xs,
   input  logic xc,
   input  logic ys,
   input  logic yc,
   input  logic cin,
   input  logic add_sub,
   output logic s,
   output logic c,
   output logic cout
);

   logic ys_inv;
   logic yc_inv;
   logic t;

   // Subtraction inverts both Y words; the matching +2 comes from the
   // add_sub bits injected at cin_0 and C[0] by the top level.
   assign ys_inv = ys ^ add_sub;
   assign yc_inv = yc ^ add_sub;

   // First full adder: cout depends only on this slice's inputs, so the
   // horizontal carry never ripples further than one slice.
   assign t    = xs ^ xc ^ ys_inv;
   assign cout = (xs & xc) | (xs & ys_inv) | (xc & ys_inv);

   // Second full adder
   assign s = yc_inv ^ cin ^ t;
   assign c = (yc_inv & cin) | (yc_inv & t) | (cin & t);

endmodule

// File: rtl/csa_addsub_pipe.sv
// Two-stage carry-save add/subtract unit for the CORDIC datapath.
// Stage 1 registers the compressed pair {S, C} from a row of 4-2 cells;
// stage 2 registers that pair together with its carry-propagate sum.
//   clk, reset      : clock, synchronous active-high reset (clears all regs)
//   flush           : synchronous clear of the valid bits only
//   in_valid/ready  : operand handshake
//   add_sub         : 0 = X+Y, 1 = X-Y
//   xs, xc, ys, yc  : redundant operands X = xs+xc, Y = ys+yc
//   out_valid/ready : result handshake
//   vs, vc          : redundant result, vs+vc = X +/- Y mod 2^W
//   sum             : resolved result
module csa_addsub_pipe
   import csa_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         add_sub,
   input  logic [W-1:0] xs,
   input  logic [W-1:0] xc,
   input  logic [W-1:0] ys,
   input  logic [W-1:0] yc,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] vs,
   output logic [W-1:0] vc,
   output logic [W-1:0] sum
);

   logic [W-1:0] cin_row;
   logic [W-1:0] s_row;
   logic [W-1:0] c_raw;
   logic [W-1:0] k_row;
   logic [W-1:0] c_row;
   logic         unused_msb_carries;

   logic [W-1:0] s1_q, s1_d;
   logic [W-1:0] c1_q, c1_d;
   logic         v1_q, v1_d;
   logic [W-1:0] vs_q, vs_d;
   logic [W-1:0] vc_q, vc_d;
   logic [W-1:0] sum_q, sum_d;
   logic         v2_q, v2_d;

   logic adv2;
   logic accept;

   // Compressor row: cin_0 and C[0] both take add_sub, completing the
   // two's-complement negation of ys and yc in subtract mode.
   assign cin_row = {k_row[W-2:0], add_sub};
   assign c_row   = {c_raw[W-2:0], add_sub};

   // Carries out of the top slice weigh 2^W and vanish mod 2^W.
   assign unused_msb_carries = k_row[W-1] ^ c_raw[W-1];

   for (genvar i = 0; i < W; i++) begin : g_row
      csa42_cell u_cell (
         .xs     (xs[i]),
         .xc     (xc[i]),
         .ys     (ys[i]),
         .yc     (yc[i]),
         .cin    (cin_row[i]),
         .add_sub(add_sub),
         .s      (s_row[i]),
         .c      (c_raw[i]),
         .cout   (k_row[i])
      );
   end

   // Stage 2 can take a new entry when it is empty or being drained; stage 1
   // can accept when it is empty or handing its entry to stage 2.
   assign adv2     = out_ready | ~v2_q;
   assign in_ready = ~v1_q | adv2;
   assign accept   = in_valid & in_ready;

   always_comb begin
      s1_d  = s1_q;
      c1_d  = c1_q;
      v1_d  = v1_q;
      vs_d  = vs_q;
      vc_d  = vc_q;
      sum_d = sum_q;
      v2_d  = v2_q;
      if (flush) begin
         // Valid bits only; data registers keep their contents.
         v1_d = 1'b0;
         v2_d = 1'b0;
      end else begin
         v1_d = accept | (v1_q & ~adv2);
         if (accept) begin
            s1_d = s_row;
            c1_d = c_row;
         end
         if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
               vs_d  = s1_q;
               vc_d  = c1_q;
               sum_d = s1_q + c1_q;
            end
         end
      end
   end

   // ---- stage 1 / stage 2 registers ----
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q  <= '0;
         c1_q  <= '0;
         v1_q  <= 1'b0;
         vs_q  <= '0;
         vc_q  <= '0;
         sum_q <= '0;
         v2_q  <= 1'b0;
      end else begin
         s1_q  <= s1_d;
         c1_q  <= c1_d;
         v1_q  <= v1_d;
         vs_q  <= vs_d;
         vc_q  <= vc_d;
         sum_q <= sum_d;
         v2_q  <= v2_d;
      end
   end

   assign out_valid = v2_q;
   assign vs        = vs_q;
   assign vc        = vc_q;
   assign sum       = sum_q;

endmodule
